wb_port_arbiter: RTL and testbench
==================================

Name: wb_port_arbiter

Overview:
- Round-robin arbiter sharing the single register-file write port among up to 8 result producers: ALU, MUL, DIV, load, CP0, HI, LO, CLZ.
- Drives the 3-bit select of the external 8:1 32-bit write-back multiplexer and receives that mux's output back.
- Issues a one-hot grant to the winning producer.
- Registers the selected data, destination address and write enable into the write-back stage, with one cycle of latency.

Parameters:
- DATA_W, 32, width of the mux output and write-back data.
- ADDR_W, 5, register-file address width.
- NREQ, 8, number of requesters; fixed at 8 to match the 3-bit select, no other value supported.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rstn  in  1  asynchronous active-low reset.
- req  in  8  request vector; bit i = producer i holds a result for write-back.
- req_addr  in  8*ADDR_W  destination register per producer; producer i at bits [i*ADDR_W +: ADDR_W].
- stall  in  1  write-back stage stalled; no grant issued, output registers hold.
- mux_y  in  DATA_W  output of the external 8:1 mux, driven by sel.
- sel  out  3  mux select = index of the current grant; 0 when no grant.
- gnt  out  8  one-hot grant, combinational, same cycle as req.
- wb_we  out  1  registered register-file write enable.
- wb_addr  out  ADDR_W  registered destination address.
- wb_data  out  DATA_W  registered write data.
- wb_src  out  3  registered index of the producer that won.
- busy  out  1  registered; 1 when any request lost arbitration or was stalled in the previous cycle.

Behaviour:
- Reset (rstn=0, async):
  - Internal pointer ptr=0.
  - wb_we=0, wb_addr=0, wb_data=0, wb_src=0, busy=0.
  - Reset asserted mid-transfer discards any pending capture. The first grant after release searches from index 0.
- Arbitration (combinational, every cycle):
  - If stall=0 and req!=0, scan indices ptr, ptr+1, …, ptr+7 (mod 8); the first i with req[i]=1 wins.
  - gnt = 1<<i and sel = i.
  - If stall=1 or req=0: gnt=0 and sel=0.
- Handshake:
  - A producer seeing gnt[i]=1 at a clock edge treats its result as consumed. It deasserts req[i] or presents its next result.
  - A request without a grant must remain asserted with stable req_addr.
  - The arbiter never grants more than one producer per cycle.
- Pointer update (clock edge):
  - On a grant to i, ptr <= (i+1) mod 8, wrapping 7 -> 0.
  - With no grant, ptr holds.
- Capture (clock edge, latency 1):
  - Grant to i: wb_data <= mux_y, wb_addr <= req_addr[i], wb_src <= i, wb_we <= (req_addr[i] != 0).
  - A write to $0 is granted and consumed but produces wb_we=0.
  - No grant and stall=0: wb_we <= 0; wb_addr, wb_data and wb_src hold.
  - stall=1: all wb_* registers hold their values, including wb_we. The stage holds its pending write.
- busy: on each edge, busy <= (popcount(req) > 1) or (stall and req!=0).
- mux_y must settle from sel within the same cycle; the arbiter adds no extra register on the select path.
- Fairness: with all 8 requests continuously asserted, each producer is granted exactly once in every 8 consecutive unstalled cycles.

Test Plan:
- Reset: hold rstn=0 with random req -> gnt=0, sel=0, wb_we=0, wb_addr=0, wb_data=0, wb_src=0, busy=0. Release; req=8'h01 -> gnt=8'h01, sel=0.
- Single request: req=8'h08, req_addr[3]=5'd9, mux_y=32'hDEAD_BEEF -> same cycle gnt=8'h08, sel=3. Next cycle wb_we=1, wb_addr=9, wb_data=32'hDEAD_BEEF, wb_src=3.
- Round-robin: req=8'hFF held 10 cycles from reset -> grant order 0,1,2,3,4,5,6,7,0,1. busy=1 from cycle 2.
- Wrap and skip: ptr=7 via a prior grant to 6; req=8'h81 -> grant 7, then grant 0 on the next cycle. With req=8'h04 and ptr=5, grant goes to 2.
- $0 write: req=8'h02, req_addr[1]=0 -> gnt=8'h02 issued. Next cycle wb_we=0, wb_src=1, and ptr advances to 2.
- Stall: wb_we=1 captured; assert stall 3 cycles with req=8'h10 -> gnt=0 and all wb_* held for the 3 cycles. On release, grant 4 and capture on the following edge.

Source files
------------

// File: rtl/wb_port_arbiter.sv
// Round-robin owner of the single register-file write port: combinational one-hot grant and mux select,
// 1-cycle registered capture into write-back; stall blocks all grants and freezes the wb_* registers.
module wb_port_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NREQ   = 8
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*ADDR_W-1:0] req_addr,
  input  logic                   stall,
  input  logic [DATA_W-1:0]      mux_y,
  output logic [2:0]             sel,
  output logic [NREQ-1:0]        gnt,
  output logic                   wb_we,
  output logic [ADDR_W-1:0]      wb_addr,
  output logic [DATA_W-1:0]      wb_data,
  output logic [2:0]             wb_src,
  output logic                   busy
);

  logic [2:0]        ptr;
  logic [2:0]        idx;
  logic              found;
  logic [ADDR_W-1:0] gnt_addr;
  logic              busy_nxt;

  // Scan starts at ptr and wraps naturally through the 3-bit index arithmetic.
  always_comb begin
    gnt   = '0;
    sel   = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = ptr + 3'(k);
      if (!found && rstn && !stall && req[idx]) begin
        found    = 1'b1;
        sel      = idx;
        gnt[idx] = 1'b1;
      end
    end
  end

  assign gnt_addr = req_addr[sel*ADDR_W +: ADDR_W];
  assign busy_nxt = ($countones(req) > 1) || (stall && (req != '0));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ptr     <= '0;
      wb_we   <= 1'b0;
      wb_addr <= '0;
      wb_data <= '0;
      wb_src  <= '0;
      busy    <= 1'b0;
    end else begin
      busy <= busy_nxt;
      if (found) begin
        ptr     <= sel + 3'd1;
        wb_data <= mux_y;
        wb_addr <= gnt_addr;
        wb_src  <= sel;
        // $0 writes are consumed like any other but never reach the register file.
        wb_we   <= (gnt_addr != '0);
      end else if (!stall) begin
        wb_we <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: hand-computed vector table, round-robin sequence and random traffic vs a reference model.
module tb_wb_port_arbiter;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic [7:0]  req = '0;
  logic [39:0] req_addr = '0;
  logic        stall = 1'b0;
  logic [31:0] mux_y = '0;
  logic [2:0]  sel;
  logic [7:0]  gnt;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic [2:0]  wb_src;
  logic        busy;

  wb_port_arbiter #(.DATA_W(32), .ADDR_W(5), .NREQ(8)) dut (
    .clk(clk), .rstn(rstn), .req(req), .req_addr(req_addr), .stall(stall), .mux_y(mux_y),
    .sel(sel), .gnt(gnt), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .wb_src(wb_src), .busy(busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference state
  int          m_ptr;
  logic        m_we;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  logic [2:0]  m_src;
  logic        m_busy;
  logic [7:0]  g_seen;
  logic [2:0]  s_seen;

  typedef struct {
    logic        stall;
    logic [7:0]  req;
    logic [39:0] ra;
    logic [31:0] muxy;
    logic [7:0]  egnt;
    logic [2:0]  esel;
    logic        ewe;
    logic [4:0]  eaddr;
    logic [2:0]  esrc;
  } vec_t;

  vec_t tbl[15];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [39:0] std_ra();
    logic [39:0] r;
    for (int i = 0; i < 8; i++) r[i*5 +: 5] = 5'(6 + i);
    return r;
  endfunction

  // Winner = first requesting index found walking forward from the pointer, modulo 8.
  function automatic int winner();
    int w;
    w = -1;
    if (rstn && !stall) begin
      for (int k = 0; k < 8; k++) begin
        int j;
        j = (m_ptr + k) % 8;
        if (w < 0 && req[j]) w = j;
      end
    end
    return w;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_we = 1'b0; m_addr = '0; m_data = '0; m_src = '0; m_busy = 1'b0;
  endtask

  task automatic cycle();
    int w;
    @(negedge clk);
    w = winner();
    g_seen = gnt;
    s_seen = sel;
    chk("gnt", 64'(gnt), (w < 0) ? 64'd0 : (64'd1 << w));
    chk("sel", 64'(sel), (w < 0) ? 64'd0 : 64'(w));
    if (w >= 0) begin
      m_data = mux_y;
      m_addr = req_addr[w*5 +: 5];
      m_src  = 3'(w);
      m_we   = (m_addr != 5'd0);
      m_ptr  = (w + 1) % 8;
    end else if (!stall) begin
      m_we = 1'b0;
    end
    m_busy = ($countones(req) > 1) || (stall && (req != 8'd0));
    @(posedge clk);
    #1;
    chk("wb_we",   64'(wb_we),   64'(m_we));
    chk("wb_addr", 64'(wb_addr), 64'(m_addr));
    chk("wb_data", 64'(wb_data), 64'(m_data));
    chk("wb_src",  64'(wb_src),  64'(m_src));
    chk("busy",    64'(busy),    64'(m_busy));
  endtask

  // Asserts reset between edges so the clear must be asynchronous.
  task automatic do_reset();
    @(posedge clk);
    #1;
    req   = 8'($urandom);
    stall = 1'b0;
    rstn  = 1'b0;
    #1;
    chk("rst_wb_we",   64'(wb_we),   64'd0);
    chk("rst_wb_addr", 64'(wb_addr), 64'd0);
    chk("rst_wb_data", 64'(wb_data), 64'd0);
    chk("rst_wb_src",  64'(wb_src),  64'd0);
    chk("rst_busy",    64'(busy),    64'd0);
    model_reset();
    @(negedge clk);
    chk("rst_gnt", 64'(gnt), 64'd0);
    chk("rst_sel", 64'(sel), 64'd0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    req  = '0;
  endtask

  initial begin
    logic [39:0] ra0;
    logic [39:0] ra1z;
    logic [63:0] r64;

    ra0  = std_ra();
    ra1z = ra0;
    ra1z[5 +: 5] = 5'd0;
    //         stall req    ra    mux_y          gnt    sel  we    addr   src
    tbl[0]  = '{1'b0, 8'h01, ra0,  32'hA000_0000, 8'h01, 3'd0, 1'b1, 5'd6,  3'd0};
    tbl[1]  = '{1'b0, 8'h08, ra0,  32'hDEAD_BEEF, 8'h08, 3'd3, 1'b1, 5'd9,  3'd3};
    tbl[2]  = '{1'b0, 8'h00, ra0,  32'hA000_0002, 8'h00, 3'd0, 1'b0, 5'd9,  3'd3};
    tbl[3]  = '{1'b0, 8'h40, ra0,  32'hA000_0003, 8'h40, 3'd6, 1'b1, 5'd12, 3'd6};
    tbl[4]  = '{1'b0, 8'h81, ra0,  32'hA000_0004, 8'h80, 3'd7, 1'b1, 5'd13, 3'd7};
    tbl[5]  = '{1'b0, 8'h81, ra0,  32'hA000_0005, 8'h01, 3'd0, 1'b1, 5'd6,  3'd0};
    tbl[6]  = '{1'b0, 8'h10, ra0,  32'hA000_0006, 8'h10, 3'd4, 1'b1, 5'd10, 3'd4};
    tbl[7]  = '{1'b0, 8'h04, ra0,  32'hA000_0007, 8'h04, 3'd2, 1'b1, 5'd8,  3'd2};
    tbl[8]  = '{1'b0, 8'h02, ra1z, 32'hA000_0008, 8'h02, 3'd1, 1'b0, 5'd0,  3'd1};
    tbl[9]  = '{1'b0, 8'hFF, ra0,  32'hA000_0009, 8'h04, 3'd2, 1'b1, 5'd8,  3'd2};
    tbl[10] = '{1'b0, 8'h10, ra0,  32'hA000_000A, 8'h10, 3'd4, 1'b1, 5'd10, 3'd4};
    tbl[11] = '{1'b1, 8'h10, ra0,  32'hA000_000B, 8'h00, 3'd0, 1'b1, 5'd10, 3'd4};
    tbl[12] = '{1'b1, 8'h10, ra0,  32'hA000_000C, 8'h00, 3'd0, 1'b1, 5'd10, 3'd4};
    tbl[13] = '{1'b1, 8'h10, ra0,  32'hA000_000D, 8'h00, 3'd0, 1'b1, 5'd10, 3'd4};
    tbl[14] = '{1'b0, 8'h10, ra0,  32'hA000_000E, 8'h10, 3'd4, 1'b1, 5'd10, 3'd4};

    model_reset();
    do_reset();

    for (int i = 0; i < 15; i++) begin
      stall    = tbl[i].stall;
      req      = tbl[i].req;
      req_addr = tbl[i].ra;
      mux_y    = tbl[i].muxy;
      cycle();
      chk($sformatf("tbl%0d_gnt", i),  64'(g_seen),  64'(tbl[i].egnt));
      chk($sformatf("tbl%0d_sel", i),  64'(s_seen),  64'(tbl[i].esel));
      chk($sformatf("tbl%0d_we", i),   64'(wb_we),   64'(tbl[i].ewe));
      chk($sformatf("tbl%0d_addr", i), 64'(wb_addr), 64'(tbl[i].eaddr));
      chk($sformatf("tbl%0d_src", i),  64'(wb_src),  64'(tbl[i].esrc));
      if (i == 1) chk("tbl1_data", 64'(wb_data), 64'h0000_0000_DEAD_BEEF);
      if (i >= 11 && i <= 13) chk($sformatf("tbl%0d_hold_data", i), 64'(wb_data), 64'h0000_0000_A000_000A);
    end
    stall = 1'b0;

    // All producers requesting: strict rotation from index 0, busy from the first edge on.
    do_reset();
    req      = 8'hFF;
    req_addr = std_ra();
    for (int c = 0; c < 10; c++) begin
      mux_y = 32'hB000_0000 + 32'(c);
      cycle();
      chk($sformatf("rr%0d_gnt", c), 64'(g_seen), 64'd1 << (c % 8));
      chk($sformatf("rr%0d_busy", c), 64'(busy), 64'd1);
    end

    do_reset();
    for (int n = 0; n < 400; n++) begin
      if (n % 100 == 99) do_reset();
      req = 8'($urandom);
      if ($urandom_range(0, 3) == 0) req = 8'hFF;
      stall = ($urandom_range(0, 4) == 0);
      mux_y = $urandom;
      r64 = {$urandom, $urandom};
      req_addr = r64[39:0];
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
